// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches one instruction at a time into the
// instruction register and holds it in EXEC until any data-memory access
// completes, then steps the PC from the jump/branch/sequential redirects.
module fetch_sequencer #(
    parameter logic [31:0] PC_INIT  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        dmem_req,
    input  logic        dhit,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic [31:0] retire_count
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retire_q, retire_d;
    logic        retire;

    // An EXEC instruction retires unless it is still waiting on data memory.
    assign retire   = (state_q == S_EXEC) && !(dmem_req && !dhit);
    assign pc_plus4 = pc_q + 32'd4;

    // State and datapath registers; reset aborts any in-flight instruction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_FETCH;
            pc_q     <= PC_INIT;
            instr_q  <= NOP_WORD;
            retire_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            retire_q <= retire_d;
        end
    end

    // Next-state: FETCH waits for ihit, EXEC leaves on retire, HALT is sticky.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (ihit) state_d = S_EXEC;
            S_EXEC:  if (retire) state_d = halt ? S_HALT : S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Datapath next values: latch fetched word, pick next PC on retire.
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        retire_d = retire_q;
        if (state_q == S_FETCH && ihit) begin
            instr_d = iload;
        end
        if (retire) begin
            retire_d = retire_q + 32'd1;
            if (halt) begin
                // HALT keeps the pc of the halting instruction and shows a NOP.
                instr_d = NOP_WORD;
            end else if (jump) begin
                pc_d = {jump_target[31:2], 2'b00};
            end else if (pc_src) begin
                pc_d = {branch_target[31:2], 2'b00};
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    // Outputs decoded from state so they follow reset without a clock edge.
    always_comb begin
        imemREN     = (state_q == S_FETCH);
        instr_valid = (state_q == S_EXEC);
        halted      = (state_q == S_HALT);
        imemaddr    = pc_q;
        pc          = pc_q;
        instr       = instr_q;
        retire_count = retire_q;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and sequencing stage that sits directly upstream of the instruction decoder / control unit in the MIPS core.
- Owns the PC and issues instruction-memory reads to the cache/memory interface.
- Latches the returned word into an instruction register that feeds decode.
- Holds each instruction in an execute phase until any data-memory access completes, then selects the next PC from the redirect inputs.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, value driven on instr at reset and in HALT.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction memory read complete; iload valid this cycle.
- iload  in  32  instruction word from instruction memory.
- dmem_req  in  1  current instruction is accessing data memory (dmemREN|dmemWEN from the request path).
- dhit  in  1  data memory access complete.
- pc_src  in  1  taken branch for the instruction in instr.
- branch_target  in  32  branch destination.
- jump  in  1  jump / jr for the instruction in instr.
- jump_target  in  32  jump destination.
- halt  in  1  instruction in instr is HALT.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  instruction read address (= pc).
- instr  out  32  instruction register, drives decode.
- instr_valid  out  1  instr is live; downstream writes are enabled only when high.
- pc  out  32  address of the instruction in instr / being fetched.
- pc_plus4  out  32  pc + 4, for jal link and branch offset base.
- halted  out  1  core has stopped.
- retire_count  out  32  instructions completed since reset.

Behaviour:
- Reset (RST high, asynchronous) forces:
  - state=FETCH, pc=PC_INIT, instr=NOP_WORD, instr_valid=0, halted=0, retire_count=0.
  - imemREN=1 immediately, since it is decoded from state.
- FETCH:
  - imemREN=1, imemaddr=pc, instr_valid=0.
  - Without ihit: hold all registers.
  - On ihit: instr<=iload, go to EXEC. Minimum fetch latency is 1 cycle (ihit in the first FETCH cycle means EXEC on the next cycle).
  - dhit, pc_src, jump and halt are ignored in FETCH.
- EXEC:
  - imemREN=0, instr_valid=1, instr held stable.
  - If dmem_req=1 and dhit=0: stay in EXEC; pc and instr unchanged.
  - Otherwise the instruction retires this cycle:
    - retire_count<=retire_count+1, wrapping at 2^32 to 0.
    - If halt=1: go to HALT with pc unchanged; pc_src and jump are ignored.
    - Else pc<= jump_target if jump; else branch_target if pc_src; else pc+4. Then go to FETCH.
    - jump has priority over pc_src.
    - The low 2 bits of every loaded target are forced to 0.
  - dhit arriving with dmem_req=0 has no effect.
- HALT:
  - imemREN=0, instr_valid=0, instr=NOP_WORD, halted=1.
  - pc and retire_count are frozen.
  - All inputs are ignored; only RST exits.
- Arithmetic:
  - pc_plus4 = pc+4 (combinational), modulo 2^32; pc=32'hFFFF_FFFC advances to 32'h0000_0000.
  - imemaddr = pc (combinational).
- At most one instruction is in flight; there is no overlap of fetch and execute.
- Reset in mid-EXEC or mid-HALT aborts the instruction without retiring it, and the next cycle after reset release fetches from PC_INIT.

Test Plan:
- Reset release, ihit after 2 cycles with iload=32'h3421_0005 -> imemaddr=0 for 3 FETCH cycles; instr=32'h3421_0005 and instr_valid=1 next cycle; then pc=4, retire_count=1, FETCH again.
- EXEC with dmem_req=1, dhit asserted on the 4th cycle -> instr_valid held 4 cycles, pc unchanged until dhit; pc=old+4 after; retire_count increments exactly once.
- EXEC with pc_src=1, branch_target=32'h0000_0040 and jump=1, jump_target=32'h0000_0103 -> next imemaddr=32'h0000_0100 (jump wins, low bits cleared).
- pc=32'hFFFF_FFFC, no redirect, instruction retires -> pc=0, pc_plus4=4.
- EXEC with halt=1 and jump=1 -> HALT; halted=1, imemREN=0, pc unchanged, retire_count+1; later ihit/dhit pulses change nothing.
- Assert RST asynchronously mid-EXEC while dmem_req=1 -> outputs return to reset values without waiting for an edge; retire_count=0; the first fetch after release is from PC_INIT.
